// File: rtl/mux8t1_8.sv
// Registered 8:1 bus selector: s picks one of I0..I7 into o, with s_q recording the index used.
// Latency: one clk edge from s/I* to o; no combinational path from any input to o.
// Backpressure: none; en=0 holds o and s_q.
module mux8t1_8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [2:0]       s,
  input  logic             en,
  output logic [WIDTH-1:0] o,
  output logic [2:0]       s_q
);

  logic [WIDTH-1:0] sel_dat;
  logic [WIDTH-1:0] o_d;
  logic [WIDTH-1:0] o_q;
  logic [2:0]       sel_idx_d;

  // Default arm falls back to I0 so an unknown select never leaves a latch or a floating bus.
  always_comb begin
    sel_dat = I0;
    case (s)
      3'd0:    sel_dat = I0;
      3'd1:    sel_dat = I1;
      3'd2:    sel_dat = I2;
      3'd3:    sel_dat = I3;
      3'd4:    sel_dat = I4;
      3'd5:    sel_dat = I5;
      3'd6:    sel_dat = I6;
      3'd7:    sel_dat = I7;
      default: sel_dat = I0;
    endcase
  end

  always_comb begin
    o_d       = o_q;
    sel_idx_d = s_q;
    if (en) begin
      o_d       = sel_dat;
      sel_idx_d = s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q <= '0;
      s_q <= '0;
    end else begin
      o_q <= o_d;
      s_q <= sel_idx_d;
    end
  end

  assign o = o_q;

endmodule

// File: tb/tb_mux8t1_8.sv
// Randomized and directed bench for mux8t1_8 against an array-indexed reference model.
module tb_mux8t1_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] din [8];
  logic [2:0] s = '0;
  logic       en = 1'b0;
  logic [7:0] o;
  logic [2:0] s_q;

  logic [7:0] exp_o = '0;
  logic [2:0] exp_s = '0;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  mux8t1_8 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .I0   (din[0]),
    .I1   (din[1]),
    .I2   (din[2]),
    .I3   (din[3]),
    .I4   (din[4]),
    .I5   (din[5]),
    .I6   (din[6]),
    .I7   (din[7]),
    .s    (s),
    .en   (en),
    .o    (o),
    .s_q  (s_q)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Model: the register takes din[s] on an enabled edge, otherwise keeps its value.
  task automatic step(input string tag);
    logic [7:0] nxt_o;
    logic [2:0] nxt_s;
    nxt_o = en ? din[s] : exp_o;
    nxt_s = en ? s : exp_s;
    @(posedge clk);
    #1;
    if (rst_n) begin
      exp_o = nxt_o;
      exp_s = nxt_s;
    end else begin
      exp_o = '0;
      exp_s = '0;
    end
    check({tag, "_o"}, {24'd0, o}, {24'd0, exp_o});
    check({tag, "_sq"}, {29'd0, s_q}, {29'd0, exp_s});
  endtask

  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    exp_o = '0;
    exp_s = '0;
    check({tag, "_rst_o"}, {24'd0, o}, 32'd0);
    check({tag, "_rst_sq"}, {29'd0, s_q}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) din[i] = 8'h11 * i[7:0];

    // Reset from power-up, then hold reset across enabled edges.
    #1 rst_n = 1'b0;
    #1;
    check("por_o", {24'd0, o}, 32'd0);
    check("por_sq", {29'd0, s_q}, 32'd0);
    en = 1'b1;
    s  = 3'd4;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_dom_o", {24'd0, o}, 32'd0);
      check("rst_dom_sq", {29'd0, s_q}, 32'd0);
    end
    rst_n = 1'b1;

    // Sweep 0..7.
    for (int i = 0; i < 8; i++) begin
      s = i[2:0];
      step("sweep");
      check("sweep_const", {24'd0, o}, 32'h11 * i);
    end

    // Wrap 7 -> 0.
    s = 3'd0;
    step("wrap");
    check("wrap_const", {24'd0, o}, 32'h00);

    // Hold.
    s = 3'd5;
    step("hold_pre");
    check("hold_pre_const", {24'd0, o}, 32'h55);
    en = 1'b0;
    s = 3'd2;
    din[5] = 8'hA5;
    step("hold");
    step("hold2");
    check("hold_const_o", {24'd0, o}, 32'h55);
    check("hold_const_sq", {29'd0, s_q}, 32'd5);
    en = 1'b1;
    step("hold_rel");
    check("hold_rel_const", {24'd0, o}, 32'h22);

    // Unselected isolation.
    din[5] = 8'h55;
    s = 3'd3;
    step("iso_pre");
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 8; i++) if (i != 3) din[i] = 8'($urandom);
      step("iso");
      check("iso_const", {24'd0, o}, 32'h33);
    end
    din[3] = 8'h3C;
    step("iso_sel");
    check("iso_sel_const", {24'd0, o}, 32'h3C);

    // Async reset mid-cycle with o=77.
    for (int i = 0; i < 8; i++) din[i] = 8'h11 * i[7:0];
    s = 3'd7;
    step("ar_pre");
    check("ar_pre_const", {24'd0, o}, 32'h77);
    reset_pulse("ar");
    s = 3'd6;
    step("ar_post");
    check("ar_post_const", {24'd0, o}, 32'h66);

    // Simultaneous change of s and selected data.
    s = 3'd1;
    step("sim_pre");
    s = 3'd4;
    din[4] = 8'hC4;
    step("sim");
    check("sim_const", {24'd0, o}, 32'hC4);

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
      s  = 3'($urandom_range(0, 7));
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) reset_pulse("rnd");
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
